// File: rtl/v_dependency_checker.sv
// Vector register scoreboard: tracks in-flight destination masks per write-port group
// and flags RAW/WAW conflicts of the candidate instruction against them.
module v_dependency_checker #(
  parameter int unsigned W_PORTS_NUM = 4,
  parameter int unsigned VREG_NUM    = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   instr_vld_i,
  input  logic [4:0]             vs1_i,
  input  logic [4:0]             vs2_i,
  input  logic [4:0]             vd_i,
  input  logic                   vs1_used_i,
  input  logic                   vs2_used_i,
  input  logic                   vd_src_i,
  input  logic                   vd_wr_i,
  input  logic [1:0]             lmul_i,
  input  logic [W_PORTS_NUM-1:0] start_i,
  input  logic [W_PORTS_NUM-1:0] port_rdy_i,
  output logic [W_PORTS_NUM-1:0] dependancy_issue_o,
  output logic [VREG_NUM-1:0]    busy_vreg_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUED,
    ST_BUSY
  } state_e;

  state_e              state_q [W_PORTS_NUM];
  state_e              state_d [W_PORTS_NUM];
  logic [VREG_NUM-1:0] mask_q  [W_PORTS_NUM];
  logic [VREG_NUM-1:0] mask_d  [W_PORTS_NUM];
  logic                cnt_q   [W_PORTS_NUM];
  logic                cnt_d   [W_PORTS_NUM];

  logic [VREG_NUM-1:0] hazard_mask;
  logic [VREG_NUM-1:0] vd_mask;

  // Register group r .. r+2^lmul-1; indices past the last register are dropped.
  function automatic logic [VREG_NUM-1:0] expand(input logic [4:0] r, input logic [1:0] lm);
    logic [VREG_NUM-1:0] m;
    int unsigned         lo;
    int unsigned         hi;
    m  = '0;
    lo = 32'(r);
    hi = lo + (32'd1 << lm);
    for (int unsigned i = 0; i < VREG_NUM; i++) begin
      m[i] = (i >= lo) && (i < hi);
    end
    return m;
  endfunction

  always_comb begin
    vd_mask     = expand(vd_i, lmul_i);
    hazard_mask = '0;
    if (vs1_used_i)           hazard_mask = hazard_mask | expand(vs1_i, lmul_i);
    if (vs2_used_i)           hazard_mask = hazard_mask | expand(vs2_i, lmul_i);
    if (vd_src_i || vd_wr_i)  hazard_mask = hazard_mask | vd_mask;
  end

  always_comb begin
    dependancy_issue_o = '0;
    busy_vreg_o        = '0;
    for (int unsigned k = 0; k < W_PORTS_NUM; k++) begin
      if (state_q[k] != ST_IDLE) begin
        busy_vreg_o = busy_vreg_o | mask_q[k];
        if (instr_vld_i && ((hazard_mask & mask_q[k]) != '0)) begin
          dependancy_issue_o[k] = 1'b1;
        end
      end
    end
  end

  // A start on group k overrides whatever clear the entry would otherwise take.
  always_comb begin
    for (int unsigned k = 0; k < W_PORTS_NUM; k++) begin
      state_d[k] = state_q[k];
      mask_d[k]  = mask_q[k];
      cnt_d[k]   = cnt_q[k];
      if (start_i[k]) begin
        cnt_d[k] = 1'b0;
        if (vd_wr_i) begin
          state_d[k] = ST_ISSUED;
          mask_d[k]  = vd_mask;
        end else begin
          state_d[k] = ST_IDLE;
          mask_d[k]  = '0;
        end
      end else begin
        case (state_q[k])
          ST_ISSUED: begin
            if (!port_rdy_i[k]) begin
              state_d[k] = ST_BUSY;
            end else if (cnt_q[k]) begin
              state_d[k] = ST_IDLE;
              mask_d[k]  = '0;
              cnt_d[k]   = 1'b0;
            end else begin
              cnt_d[k] = 1'b1;
            end
          end
          ST_BUSY: begin
            if (port_rdy_i[k]) begin
              state_d[k] = ST_IDLE;
              mask_d[k]  = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < W_PORTS_NUM; k++) begin
      if (!rstn) begin
        state_q[k] <= ST_IDLE;
        mask_q[k]  <= '0;
        cnt_q[k]   <= 1'b0;
      end else begin
        state_q[k] <= state_d[k];
        mask_q[k]  <= mask_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_v_dependency_checker.sv
// Scoreboard bench for v_dependency_checker: directed scenarios plus a randomized run
// against a behavioural model.
module tb_v_dependency_checker;

  logic        clk;
  logic        rstn;
  logic        instr_vld_i;
  logic [4:0]  vs1_i;
  logic [4:0]  vs2_i;
  logic [4:0]  vd_i;
  logic        vs1_used_i;
  logic        vs2_used_i;
  logic        vd_src_i;
  logic        vd_wr_i;
  logic [1:0]  lmul_i;
  logic [3:0]  start_i;
  logic [3:0]  port_rdy_i;
  logic [3:0]  dependancy_issue_o;
  logic [31:0] busy_vreg_o;

  typedef struct {
    logic [3:0]  dep;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  v_dependency_checker #(.W_PORTS_NUM(4), .VREG_NUM(32)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .instr_vld_i        (instr_vld_i),
    .vs1_i              (vs1_i),
    .vs2_i              (vs2_i),
    .vd_i               (vd_i),
    .vs1_used_i         (vs1_used_i),
    .vs2_used_i         (vs2_used_i),
    .vd_src_i           (vd_src_i),
    .vd_wr_i            (vd_wr_i),
    .lmul_i             (lmul_i),
    .start_i            (start_i),
    .port_rdy_i         (port_rdy_i),
    .dependancy_issue_o (dependancy_issue_o),
    .busy_vreg_o        (busy_vreg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cand(input logic v, input logic [4:0] a, input logic ua, input logic [4:0] b,
                      input logic ub, input logic [4:0] d, input logic ds, input logic dw,
                      input logic [1:0] lm);
    instr_vld_i = v;  vs1_i = a;  vs1_used_i = ua;  vs2_i = b;  vs2_used_i = ub;
    vd_i = d;  vd_src_i = ds;  vd_wr_i = dw;  lmul_i = lm;
  endtask

  task automatic test_reset;
    rstn = 1'b0;  start_i = '0;  port_rdy_i = '1;
    cand(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cand(1, 0, 1, 0, 1, 0, 1, 1, 3);
    exp_q.push_back('{dep: 4'b0000, busy: 32'h0});
    #1 e = exp_q.pop_front();
    checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL reset_dep: got %b expected %b", dependancy_issue_o, e.dep); end
    checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy_vreg_o, e.busy); end
  endtask

  task automatic test_raw;
    logic [3:0]  dep_l [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000};
    logic [31:0] bsy_l [4] = '{32'h0, 32'h30, 32'h30, 32'h0};
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      case (s)
        0: begin cand(0, 0, 0, 0, 0, 4, 0, 1, 1); start_i = 4'b0001; port_rdy_i = 4'hF; end
        1: begin cand(1, 5, 1, 0, 0, 0, 0, 0, 1); start_i = '0; port_rdy_i = 4'b1110; end
        2: port_rdy_i = 4'hF;
        default: ;
      endcase
      exp_q.push_back('{dep: dep_l[s], busy: bsy_l[s]});
      #1 e = exp_q.pop_front();
      checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL raw_dep[%0d]: got %b expected %b", s, dependancy_issue_o, e.dep); end
      checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL raw_busy[%0d]: got %h expected %h", s, busy_vreg_o, e.busy); end
    end
  endtask

  task automatic test_no_hazard;
    @(negedge clk);
    cand(0, 0, 0, 0, 0, 4, 0, 1, 1); start_i = 4'b0001; port_rdy_i = 4'hF;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      start_i = '0;
      case (s)
        0: begin cand(1, 6, 1, 3, 1, 7, 0, 1, 0); port_rdy_i = 4'b1110;
                 exp_q.push_back('{dep: 4'b0000, busy: 32'h30}); end
        1: begin cand(0, 4, 1, 0, 0, 0, 0, 0, 0);
                 exp_q.push_back('{dep: 4'b0000, busy: 32'h30}); end
        2: begin cand(1, 4, 1, 0, 0, 0, 0, 0, 0); port_rdy_i = 4'hF;
                 exp_q.push_back('{dep: 4'b0001, busy: 32'h30}); end
        default: exp_q.push_back('{dep: 4'b0000, busy: 32'h0});
      endcase
      #1 e = exp_q.pop_front();
      checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL nohaz_dep[%0d]: got %b expected %b", s, dependancy_issue_o, e.dep); end
      checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL nohaz_busy[%0d]: got %h expected %h", s, busy_vreg_o, e.busy); end
    end
  endtask

  task automatic test_clamp;
    @(negedge clk);
    cand(0, 0, 0, 0, 0, 30, 0, 1, 3); start_i = 4'b0100; port_rdy_i = 4'hF;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      start_i = '0;
      case (s)
        0: begin cand(1, 0, 0, 0, 1, 0, 0, 0, 3); port_rdy_i = 4'b1011;
                 exp_q.push_back('{dep: 4'b0000, busy: 32'hC000_0000}); end
        1: begin cand(1, 31, 1, 0, 0, 0, 0, 0, 0);
                 exp_q.push_back('{dep: 4'b0100, busy: 32'hC000_0000}); end
        2: begin cand(1, 24, 1, 0, 0, 0, 0, 0, 2); port_rdy_i = 4'hF;
                 exp_q.push_back('{dep: 4'b0000, busy: 32'hC000_0000}); end
        default: begin cand(1, 30, 1, 0, 0, 0, 0, 0, 0);
                 exp_q.push_back('{dep: 4'b0000, busy: 32'h0}); end
      endcase
      #1 e = exp_q.pop_front();
      checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL clamp_dep[%0d]: got %b expected %b", s, dependancy_issue_o, e.dep); end
      checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL clamp_busy[%0d]: got %h expected %h", s, busy_vreg_o, e.busy); end
    end
  endtask

  task automatic test_zero_length;
    logic [3:0]  dep_l [4] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000};
    logic [31:0] bsy_l [4] = '{32'h0, 32'h400, 32'h400, 32'h0};
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      port_rdy_i = 4'hF;
      if (s == 0) begin cand(1, 10, 1, 0, 0, 10, 0, 1, 0); start_i = 4'b0010; end
      else begin cand(1, 10, 1, 0, 0, 0, 0, 0, 0); start_i = '0; end
      exp_q.push_back('{dep: dep_l[s], busy: bsy_l[s]});
      #1 e = exp_q.pop_front();
      checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL zlen_dep[%0d]: got %b expected %b", s, dependancy_issue_o, e.dep); end
      checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL zlen_busy[%0d]: got %h expected %h", s, busy_vreg_o, e.busy); end
    end
  endtask

  task automatic test_restart;
    @(negedge clk);
    cand(0, 0, 0, 0, 0, 8, 0, 1, 0); start_i = 4'b1000; port_rdy_i = 4'hF;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      start_i = '0;
      case (s)
        0: begin cand(1, 8, 1, 0, 0, 0, 0, 0, 0); port_rdy_i = 4'b0111;
                 exp_q.push_back('{dep: 4'b1000, busy: 32'h100}); end
        1: begin cand(1, 8, 1, 0, 0, 12, 0, 1, 0); port_rdy_i = 4'hF; start_i = 4'b1000;
                 exp_q.push_back('{dep: 4'b1000, busy: 32'h100}); end
        2: begin cand(1, 8, 1, 0, 0, 0, 0, 0, 0);
                 exp_q.push_back('{dep: 4'b0000, busy: 32'h1000}); end
        3: begin cand(1, 12, 1, 0, 0, 0, 0, 0, 0);
                 exp_q.push_back('{dep: 4'b1000, busy: 32'h1000}); end
        default: exp_q.push_back('{dep: 4'b0000, busy: 32'h0});
      endcase
      #1 e = exp_q.pop_front();
      checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL restart_dep[%0d]: got %b expected %b", s, dependancy_issue_o, e.dep); end
      checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL restart_busy[%0d]: got %h expected %h", s, busy_vreg_o, e.busy); end
    end
  endtask

  task automatic test_no_write_start;
    @(negedge clk);
    cand(0, 0, 0, 0, 0, 20, 0, 1, 0); start_i = 4'b0001; port_rdy_i = 4'hF;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      start_i = '0;
      case (s)
        0: begin port_rdy_i = 4'b1110; exp_q.push_back('{dep: 4'b0000, busy: 32'h10_0000}); end
        1: begin cand(0, 0, 0, 0, 0, 20, 0, 0, 0); start_i = 4'b0001;
                 exp_q.push_back('{dep: 4'b0000, busy: 32'h10_0000}); end
        default: begin cand(1, 20, 1, 0, 0, 0, 0, 0, 0);
                 exp_q.push_back('{dep: 4'b0000, busy: 32'h0}); end
      endcase
      #1 e = exp_q.pop_front();
      checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL nowr_dep[%0d]: got %b expected %b", s, dependancy_issue_o, e.dep); end
      checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL nowr_busy[%0d]: got %h expected %h", s, busy_vreg_o, e.busy); end
    end
    @(negedge clk);
    port_rdy_i = 4'hF;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cand(0, 0, 0, 0, 0, 2, 0, 1, 1); start_i = 4'b0011; port_rdy_i = 4'hF;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      start_i = '0;
      case (s)
        0: begin cand(1, 3, 1, 0, 0, 0, 0, 0, 0); port_rdy_i = 4'b1100;
                 exp_q.push_back('{dep: 4'b0011, busy: 32'hC}); end
        1: exp_q.push_back('{dep: 4'b0011, busy: 32'hC});
        2: begin rstn = 1'b0; exp_q.push_back('{dep: 4'b0011, busy: 32'hC}); end
        default: begin rstn = 1'b1; exp_q.push_back('{dep: 4'b0000, busy: 32'h0}); end
      endcase
      #1 e = exp_q.pop_front();
      checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL rstmid_dep[%0d]: got %b expected %b", s, dependancy_issue_o, e.dep); end
      checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL rstmid_busy[%0d]: got %h expected %h", s, busy_vreg_o, e.busy); end
    end
    port_rdy_i = 4'hF;
  endtask

  function automatic logic [31:0] mexp(input logic [4:0] r, input logic [1:0] lm);
    logic [63:0] t;
    t = ((64'd1 << (4'd1 << lm)) - 64'd1) << r;
    return t[31:0];
  endfunction

  // Model states: 0 idle, 1 issued, 2 busy.
  task automatic test_random;
    int          ms [4] = '{0, 0, 0, 0};
    logic [31:0] mm [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    bit          mc [4] = '{0, 0, 0, 0};
    logic [31:0] hz;
    exp_t        x;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rstn        = ($urandom_range(39) != 0);
      instr_vld_i = ($urandom_range(3) != 0);
      vs1_i = 5'($urandom);  vs2_i = 5'($urandom);  vd_i = 5'($urandom);
      vs1_used_i = 1'($urandom);  vs2_used_i = 1'($urandom);
      vd_src_i = 1'($urandom);  vd_wr_i = ($urandom_range(3) != 0);
      lmul_i = 2'($urandom);
      start_i = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      port_rdy_i = 4'($urandom) | 4'($urandom);
      hz = '0;
      if (vs1_used_i) hz |= mexp(vs1_i, lmul_i);
      if (vs2_used_i) hz |= mexp(vs2_i, lmul_i);
      if (vd_src_i || vd_wr_i) hz |= mexp(vd_i, lmul_i);
      x.dep = '0;  x.busy = '0;
      for (int k = 0; k < 4; k++) begin
        if (ms[k] != 0) x.busy |= mm[k];
        x.dep[k] = instr_vld_i && (ms[k] != 0) && ((hz & mm[k]) != 0);
      end
      exp_q.push_back(x);
      #1 e = exp_q.pop_front();
      checks++; if (dependancy_issue_o !== e.dep) begin errors++; $display("FAIL rand_dep[%0d]: got %b expected %b", n, dependancy_issue_o, e.dep); end
      checks++; if (busy_vreg_o !== e.busy) begin errors++; $display("FAIL rand_busy[%0d]: got %h expected %h", n, busy_vreg_o, e.busy); end
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
        if (!rstn) begin
          ms[k] = 0;  mm[k] = '0;  mc[k] = 0;
        end else if (start_i[k]) begin
          ms[k] = vd_wr_i ? 1 : 0;
          mm[k] = vd_wr_i ? mexp(vd_i, lmul_i) : 32'h0;
          mc[k] = 0;
        end else if (ms[k] == 1 && !port_rdy_i[k]) begin
          ms[k] = 2;
        end else if (ms[k] == 1 && mc[k]) begin
          ms[k] = 0;  mm[k] = '0;  mc[k] = 0;
        end else if (ms[k] == 1) begin
          mc[k] = 1;
        end else if (ms[k] == 2 && port_rdy_i[k]) begin
          ms[k] = 0;  mm[k] = '0;
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_raw;
    test_no_hazard;
    test_clamp;
    test_zero_length;
    test_restart;
    test_no_write_start;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
